ram_port_arbiter: RTL

//  Shares one single-port RAM (DEPTH x DATA_W, registered read) between two requesters.
//  - Round-robin arbitration; each requester uses a valid/ready handshake.
//  - After reset the block clears the RAM before any requester is served.
//  - Sits between the small datapath registers/RAMs and the blocks that need table access.

---
 rtl/ram_arb_pkg.sv | 12 +
 rtl/ram_port_arbiter_ram_1rw.sv | 31 +++
 rtl/ram_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM arbiter: sequencer states and requester indices.
package ram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_ram_1rw.sv
// Single-port RAM, one access per cycle; read data registered (1-cycle latency), no backpressure.
module ram_1rw #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately unreset; the arbiter clears it after every reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin share of one 1RW RAM between m0/m1; reads return 1 cycle after acceptance.
// Ready is combinational from valid; nothing is served until the post-reset clear finishes.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              init_done
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_rr_ptr;
  logic              r_rd_pend;
  logic              r_rd_owner;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc;
  logic              w_acc_id;
  logic              w_ram_en;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    unique case (r_state)
      INIT: begin
        w_ram_en   = 1'b1;
        w_ram_we   = 1'b1;
        w_ram_addr = r_init_cnt;
        if (r_init_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // No handshake completes in a reset cycle, so nothing is lost to the restart.
        if (!rst) begin
          w_gnt0 = m0_valid & (~m1_valid | (r_rr_ptr == REQ_M0));
          w_gnt1 = m1_valid & (~m0_valid | (r_rr_ptr == REQ_M1));
        end
        if (w_gnt0) begin
          w_ram_en    = 1'b1;
          w_ram_we    = m0_we;
          w_ram_addr  = m0_addr;
          w_ram_wdata = m0_wdata;
        end else if (w_gnt1) begin
          w_ram_en    = 1'b1;
          w_ram_we    = m1_we;
          w_ram_addr  = m1_addr;
          w_ram_wdata = m1_wdata;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  assign w_acc    = w_gnt0 | w_gnt1;
  assign w_acc_id = w_gnt1 ? REQ_M1 : REQ_M0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_rr_ptr   <= REQ_M0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= REQ_M0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) begin
        r_init_cnt <= r_init_cnt + ADDR_W'(1);
      end
      if (w_acc) begin
        r_rr_ptr   <= ~w_acc_id;
        r_rd_owner <= w_acc_id;
      end
      r_rd_pend <= w_acc & ~w_ram_we;
      if (m0_rvalid) begin
        r_m0_rdata <= w_ram_rdata;
      end
      if (m1_rvalid) begin
        r_m1_rdata <= w_ram_rdata;
      end
    end
  end

  assign m0_ready  = w_gnt0;
  assign m1_ready  = w_gnt1;
  assign init_done = (r_state == RUN) & ~rst;
  assign m0_rvalid = r_rd_pend & (r_rd_owner == REQ_M0) & ~rst;
  assign m1_rvalid = r_rd_pend & (r_rd_owner == REQ_M1) & ~rst;
  // Fresh RAM output on the rvalid cycle, captured copy afterwards.
  assign m0_rdata  = m0_rvalid ? w_ram_rdata : r_m0_rdata;
  assign m1_rdata  = m1_rvalid ? w_ram_rdata : r_m1_rdata;

  ram_1rw #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .en   (w_ram_en),
    .we   (w_ram_we),
    .addr (w_ram_addr),
    .wdata(w_ram_wdata),
    .rdata(w_ram_rdata)
  );

endmodule
